fetch_unit: RTL and testbench

Instruction fetch and sequencing stage feeding the processor control unit. Holds the program counter and reads 9-bit words from a synchronous instruction ROM. Presents each instruction on `ir`, and for MVI the following immediate word on `din`. Holds `run` until the control unit returns `done`, then advances to the next instruction.

---
 rtl/proc_pkg.sv | 24 ++
 rtl/pc_counter.sv | 20 ++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Opcodes and fetch-state encoding shared between the fetch unit and the control unit.
// Instruction format is III XXX YYY; the opcode is the top three bits of the word.
package proc_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_F0,
        S_F1,
        S_I0,
        S_I1,
        S_EXEC,
        S_HALT
    } fetch_state_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter: ADDR_W-bit up-counter with async clear and increment enable.
// Wraps from 2^ADDR_W-1 to 0 by natural modulo arithmetic.
module pc_counter #(
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              inc,
    output logic [ADDR_W-1:0] count
);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch/sequencing stage: reads instruction (and MVI immediate) words from a 1-cycle ROM,
// presents them on ir/din and holds run until the control unit returns done.
module fetch_unit
    import proc_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 9
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              enable,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W:0]   ir,
    output logic [DATA_W-1:0] din,
    output logic              run,
    input  logic              done,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic         pc_inc;
    logic         ld_ir;
    logic         ld_din;
    logic         set_halt;
    logic [2:0]   opcode;

    assign opcode = mem_data[DATA_W-1 -: 3];

    pc_counter #(
        .ADDR_W(ADDR_W)
    ) u_pc (
        .clock (clock),
        .resetn(resetn),
        .inc   (pc_inc),
        .count (pc)
    );

    // The ROM is always addressed by pc; the data phase sees the word for the previous cycle's pc.
    assign mem_addr = pc;

    // Combinational so run is already low on the edge where done is sampled.
    assign run = (state == S_EXEC) && !done;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= S_IDLE;
            ir     <= '0;
            din    <= '0;
            halted <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ld_ir) begin
                ir <= {1'b0, mem_data};
            end
            if (ld_din) begin
                din <= mem_data;
            end
            if (set_halt) begin
                halted <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pc_inc    = 1'b0;
        ld_ir     = 1'b0;
        ld_din    = 1'b0;
        set_halt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_nxt = S_F0;
                end
            end
            S_F0: state_nxt = S_F1;
            S_F1: begin
                ld_ir  = 1'b1;
                pc_inc = 1'b1;
                if (opcode == OP_HALT) begin
                    state_nxt = S_HALT;
                    set_halt  = 1'b1;
                end else if (opcode == OP_MVI) begin
                    state_nxt = S_I0;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_I0: state_nxt = S_I1;
            S_I1: begin
                ld_din    = 1'b1;
                pc_inc    = 1'b1;
                state_nxt = S_EXEC;
            end
            // A fetch already under way completes even if enable drops; enable only
            // decides whether the next fetch starts after done.
            S_EXEC: begin
                if (done) begin
                    state_nxt = enable ? S_F0 : S_IDLE;
                end
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: ROM model plus a program-level reference of pc/ir/din/latency.
module tb_fetch_unit;
    import proc_pkg::*;

    logic       clock = 1'b0;
    logic       resetn;
    logic       enable;
    logic       done;
    logic [4:0] mem_addr;
    logic [8:0] mem_data = '0;
    logic [9:0] ir;
    logic [8:0] din;
    logic       run;
    logic [4:0] pc;
    logic       halted;

    int checks = 0;
    int errors = 0;

    logic [8:0] rom [32];
    logic [4:0] mpc;
    logic [8:0] mdin;

    fetch_unit #(.ADDR_W(5), .DATA_W(9)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .enable  (enable),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .ir      (ir),
        .din     (din),
        .run     (run),
        .done    (done),
        .pc      (pc),
        .halted  (halted)
    );

    always #5 clock = ~clock;

    always @(posedge clock) mem_data <= rom[mem_addr];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [8:0] rand_word(input bit allow_mvi);
        logic [2:0] op;
        logic [8:0] w;
        op = 3'($urandom_range(0, 6));
        if (!allow_mvi && op == OP_MVI) op = OP_ADD;
        w = 9'($urandom);
        w[8:6] = op;
        return w;
    endfunction

    task automatic do_reset();
        resetn = 1'b0;
        enable = 1'b0;
        done   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        tick();
        mpc  = '0;
        mdin = '0;
    endtask

    // Precondition: the unit has just entered F0 for the word at mpc.
    task automatic exec_instr(input int drop_at, input int hold);
        logic [8:0] w;
        logic [9:0] exp_ir;
        int lat;
        int k;
        w = rom[mpc];
        exp_ir = {1'b0, w};
        mpc = mpc + 5'd1;
        if (w[8:6] == OP_MVI) begin
            mdin = rom[mpc];
            mpc = mpc + 5'd1;
            lat = 4;
        end else begin
            lat = 2;
        end
        k = 0;
        while (run !== 1'b1 && k < 8) begin
            if (k == drop_at) enable = 1'b0;
            done = (k < lat) ? 1'($urandom) : 1'b0;
            tick();
            done = 1'b0;
            #1;
            k++;
        end
        checks++;
        if (k !== lat) begin
            errors++;
            $display("FAIL latency: got %0d cycles, expected %0d (word %h)", k, lat, w);
        end
        checks++;
        if (ir !== exp_ir) begin
            errors++;
            $display("FAIL ir: got %h, expected %h", ir, exp_ir);
        end
        checks++;
        if (din !== mdin) begin
            errors++;
            $display("FAIL din: got %h, expected %h", din, mdin);
        end
        checks++;
        if (pc !== mpc || mem_addr !== mpc) begin
            errors++;
            $display("FAIL pc_at_run: got pc=%0d mem_addr=%0d, expected %0d", pc, mem_addr, mpc);
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            checks++;
            if (run !== 1'b1 || ir !== exp_ir || din !== mdin) begin
                errors++;
                $display("FAIL hold: got run=%b ir=%h din=%h, expected run=1 ir=%h din=%h",
                         run, ir, din, exp_ir, mdin);
            end
        end
        done = 1'b1;
        #1;
        checks++;
        if (run !== 1'b0) begin
            errors++;
            $display("FAIL run_on_done: got %b, expected 0", run);
        end
        tick();
        done = 1'b0;
        #1;
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            done = 1'($urandom);
            tick();
            done = 1'b0;
            #1;
            checks++;
            if (run !== 1'b0 || pc !== mpc) begin
                errors++;
                $display("FAIL idle: got run=%b pc=%0d, expected run=0 pc=%0d", run, pc, mpc);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 32; i++) rom[i] = rand_word(1'b1);
        do_reset();
        checks++;
        if (pc !== 5'd0 || mem_addr !== 5'd0) begin
            errors++;
            $display("FAIL reset_pc: got pc=%0d mem_addr=%0d, expected 0", pc, mem_addr);
        end
        checks++;
        if (ir !== 10'd0 || din !== 9'd0) begin
            errors++;
            $display("FAIL reset_ir_din: got ir=%h din=%h, expected 0", ir, din);
        end
        checks++;
        if (run !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got run=%b halted=%b, expected 0 0", run, halted);
        end
        idle_check(4);
    endtask

    task automatic test_directed_program();
        int k;
        for (int i = 0; i < 32; i++) rom[i] = rand_word(1'b1);
        rom[0] = 9'b000_001_010;
        rom[1] = 9'b001_011_000;
        rom[2] = 9'h15A;
        rom[3] = 9'b111_000_000;
        do_reset();
        enable = 1'b1;
        tick();
        exec_instr(-1, 3);
        checks++;
        if (pc !== 5'd1 || mem_addr !== 5'd1) begin
            errors++;
            $display("FAIL after_mv_pc: got pc=%0d, expected 1", pc);
        end
        exec_instr(-1, 2);
        checks++;
        if (ir !== 10'h058 || din !== 9'h15A) begin
            errors++;
            $display("FAIL mvi_regs: got ir=%h din=%h, expected 058 15a", ir, din);
        end
        k = 0;
        while (halted !== 1'b1 && k < 6) begin
            tick();
            k++;
        end
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_flag: got %b, expected 1", halted);
        end
        for (int i = 0; i < 20; i++) begin
            done = 1'($urandom);
            tick();
            done = 1'b0;
            #1;
            checks++;
            if (run !== 1'b0 || mem_addr !== 5'd4 || halted !== 1'b1) begin
                errors++;
                $display("FAIL halted_frozen: got run=%b mem_addr=%0d halted=%b, expected 0 4 1",
                         run, mem_addr, halted);
            end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 31; i++) rom[i] = rand_word(1'b0);
        rom[31] = rand_word(1'b0);
        rom[31][8:6] = OP_MVI;
        do_reset();
        enable = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) exec_instr(-1, $urandom_range(0, 2));
        checks++;
        if (din !== rom[0] || pc !== 5'd1) begin
            errors++;
            $display("FAIL wrap: got din=%h pc=%0d, expected din=%h pc=1", din, pc, rom[0]);
        end
    endtask

    task automatic test_enable_drop();
        for (int i = 0; i < 32; i++) rom[i] = rand_word(1'b1);
        rom[0] = rand_word(1'b0);
        rom[0][8:6] = OP_ADD;
        do_reset();
        enable = 1'b1;
        tick();
        exec_instr(1, 2);
        idle_check(5);
        enable = 1'b1;
        tick();
        exec_instr(-1, 1);
    endtask

    task automatic test_random_program();
        for (int i = 0; i < 32; i++) rom[i] = rand_word(1'b1);
        do_reset();
        enable = 1'b1;
        tick();
        for (int n = 0; n < 48; n++) begin
            exec_instr(($urandom_range(0, 3) == 0) ? $urandom_range(0, 1) : -1,
                       $urandom_range(0, 3));
            if (enable == 1'b0) begin
                idle_check($urandom_range(1, 4));
                enable = 1'b1;
                tick();
            end
        end
    endtask

    task automatic test_reset_mid_exec();
        int k;
        for (int i = 0; i < 32; i++) rom[i] = rand_word(1'b0);
        do_reset();
        enable = 1'b1;
        tick();
        k = 0;
        while (run !== 1'b1 && k < 8) begin
            tick();
            k++;
        end
        tick();
        resetn = 1'b0;
        #1;
        checks++;
        if (run !== 1'b0 || ir !== 10'd0 || pc !== 5'd0 || din !== 9'd0) begin
            errors++;
            $display("FAIL async_reset: got run=%b ir=%h pc=%0d din=%h, expected all 0",
                     run, ir, pc, din);
        end
        tick();
        resetn = 1'b1;
        enable = 1'b0;
        done   = 1'b1;
        tick();
        done = 1'b0;
        tick();
        checks++;
        if (run !== 1'b0 || pc !== 5'd0 || ir !== 10'd0) begin
            errors++;
            $display("FAIL done_after_reset: got run=%b pc=%0d ir=%h, expected 0 0 0", run, pc, ir);
        end
    endtask

    initial begin
        resetn = 1'b0;
        enable = 1'b0;
        done   = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = '0;
        test_reset();
        test_directed_program();
        test_wrap();
        test_enable_drop();
        test_random_program();
        test_reset_mid_exec();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
